store_drain_buffer: RTL and testbench

- Sits directly downstream of the single-cycle core's data-memory port.
- The core has no stall input, so every cycle with `mem_we=1` is a store that must be captured in that same cycle.
- Captured stores (`mem_addr`/`mem_data`) go into a circular FIFO. The FIFO drains to a slower memory/peripheral bus over a valid/ready handshake.
- Losses caused by overflow are reported through a sticky flag.

---
 rtl/store_drain_buffer.sv | 98 +++++++++
 tb/tb_store_drain_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// Store drain buffer: captures every core store into a circular FIFO and drains it over valid/ready.
// Optional macro STORE_MERGE_EN merges a store into the newest entry when the addresses match.
module store_drain_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic push;
  logic pop;
  logic drop;
  logic merge;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_valid = !empty;
  assign out_addr  = addr_mem[rd_ptr];
  assign out_data  = data_mem[rd_ptr];

  assign pop = out_valid && out_ready;

`ifdef STORE_MERGE_EN
  logic [PW-1:0] newest_idx;
  assign newest_idx = wr_ptr - PW'(1);
  // With a single entry the newest is also the head; if it is leaving we must allocate instead.
  assign merge = mem_we && !empty && (addr_mem[newest_idx] == mem_addr)
                 && !(pop && (count_q == CW'(1)));
`else
  assign merge = 1'b0;
`endif

  assign push = mem_we && !merge && (!full || pop);
  assign drop = mem_we && !merge && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  // Storage carries no reset; contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= mem_addr;
      data_mem[wr_ptr] <= mem_data;
    end
`ifdef STORE_MERGE_EN
    else if (merge) begin
      data_mem[newest_idx] <= mem_data;
    end
`endif
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Scoreboard bench for store_drain_buffer: stimulus queues expected drains, a negedge monitor checks them.
// Honours STORE_MERGE_EN when the same macro is defined for the bench.
module tb_store_drain_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              overflow_clr = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  store_drain_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit expect_alloc);
    mem_we = 1'b1; mem_addr = a; mem_data = d;
    if (expect_alloc) exp_q.push_back({a, d});
    tick();
    mem_we = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (empty) begin done = 1; break; end
      tick();
    end
    out_ready = 1'b0;
    chk({name, "_drained"}, {63'd0, done}, 64'd1);
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a pop happens at the next posedge whenever valid and ready are both high now.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: got %0h/%0h expected none", out_addr, out_data);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_addr, out_data} !== e) begin
          failures++;
          $display("FAIL drain_order: got %0h/%0h expected %0h/%0h",
                   out_addr, out_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pops0;
    // Scenario 1: reset state, first store with one-cycle latency
    #3;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    store(32'h10, 32'hAA, 1);
    chk("s1_valid", {63'd0, out_valid}, 64'd1);
    chk("s1_addr", 64'(out_addr), 64'h10);
    chk("s1_data", 64'(out_data), 64'hAA);
    chk("s1_count", 64'(count), 64'd1);
    drain("s1");

    // Scenario 2: fill, overflow drop, in-order drain, clear
    for (int i = 0; i < 8; i++) store(32'(4 * i), 32'(i + 1), 1);
    chk("s2_full", {63'd0, full}, 64'd1);
    chk("s2_count", 64'(count), 64'd8);
    store(32'h20, 32'h9, 0);
    chk("s2_ovf", {63'd0, overflow}, 64'd1);
    chk("s2_count_drop", 64'(count), 64'd8);
    drain("s2");
    chk("s2_ovf_sticky", {63'd0, overflow}, 64'd1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("s2_ovf_clr", {63'd0, overflow}, 64'd0);

    // Scenario 3: drop beats clear; full with push and pop keeps count
    for (int i = 0; i < 8; i++) store(32'(32'h80 + 4 * i), 32'(32'h100 + i), 1);
    overflow_clr = 1'b1;
    store(32'h3C, 32'hEE, 0);
    overflow_clr = 1'b0;
    chk("s3_drop_wins", {63'd0, overflow}, 64'd1);
    chk("s3_count_drop", 64'(count), 64'd8);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    out_ready = 1'b1;
    store(32'h40, 32'h55, 1);
    chk("s3_count_pp", 64'(count), 64'd8);
    chk("s3_ovf_none", {63'd0, overflow}, 64'd0);
    drain("s3");

    // Scenario 4: streaming at count==1 across pointer wraps
    pops0 = pops;
    store(32'h300, 32'h200, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_we = 1'b1; mem_addr = 32'(32'h304 + 4 * i); mem_data = 32'(32'h201 + i);
      exp_q.push_back({mem_addr, mem_data});
      tick();
      chk("s4_count", 64'(count), 64'd1);
    end
    mem_we = 1'b0;
    drain("s4");
    chk("s4_pops", 64'(pops - pops0), 64'd21);

    // Empty with out_ready: nothing moves
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    chk("empty_ready_count", 64'(count), 64'd0);
    chk("empty_ready_empty", {63'd0, empty}, 64'd1);

    // Scenario 5: async reset mid-drain at count 5
    for (int i = 0; i < 6; i++) store(32'(32'h500 + 4 * i), 32'(32'h50 + i), 1);
    out_ready = 1'b1;
    tick();
    chk("s5_count_before", 64'(count), 64'd5);
    rst = 1'b1;
    #1;
    chk("s5_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("s5_rst_count", 64'(count), 64'd0);
    chk("s5_rst_empty", {63'd0, empty}, 64'd1);
    exp_q.delete();
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    store(32'h10, 32'hAA, 1);
    chk("s5_valid", {63'd0, out_valid}, 64'd1);
    chk("s5_addr", 64'(out_addr), 64'h10);
    chk("s5_data", 64'(out_data), 64'hAA);
    chk("s5_count", 64'(count), 64'd1);
    drain("s5");

    // Scenario 6: same-address back-to-back stores
`ifdef STORE_MERGE_EN
    store(32'h8, 32'h1, 0);
    store(32'h8, 32'h2, 1);
    chk("s6_count", 64'(count), 64'd1);
    chk("s6_data", 64'(out_data), 64'h2);
`else
    store(32'h8, 32'h1, 1);
    store(32'h8, 32'h2, 1);
    chk("s6_count", 64'(count), 64'd2);
    chk("s6_data", 64'(out_data), 64'h1);
`endif
    drain("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
